// File: rtl/cons_hist_pkg.sv
// ============================================================================
// Module   : cons_hist_pkg
// Purpose  : Shared definitions for the histogram consumer and its bench:
//            default widths/sizes and the FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cons_hist_pkg;

  // Default geometry of the producer/consumer pair
  localparam int DW_DEF     = 8;
  localparam int NBINS_DEF  = 6;
  localparam int CW_DEF     = 8;
  localparam int WINDOW_DEF = 100;

  // Width of the accepted-sample counter
  localparam int TOTAL_W = 16;

  // FSM state encoding
  typedef logic [0:0] state_t;
  localparam state_t ST_COLLECT = 1'b0;
  localparam state_t ST_HOLD    = 1'b1;

endpackage : cons_hist_pkg

`default_nettype wire

// File: rtl/cons_hist_bin.sv
// ============================================================================
// Module   : hist_bin
// Purpose  : One saturating histogram bin counter.
// Ports    : clk     - clock
//            rst     - synchronous active-high reset
//            clr_i   - synchronous clear (same effect as reset)
//            inc_i   - increment request; ignored once the counter is full
//            cnt_o   - current count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hist_bin
  import cons_hist_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] C_MAX = '1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != C_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : hist_bin

`default_nettype wire

// File: rtl/cons_hist.sv
// ============================================================================
// Module   : cons_hist
// Purpose  : Histogram consumer. Counts valid in-range samples per value over
//            a window of WINDOW accepted samples, then freezes until clr.
//            Out-of-range samples set a sticky error flag. Bins are read
//            through a registered read port.
// Ports    : clk      - clock
//            rst      - synchronous active-high reset
//            data     - sample (DW bits)
//            val      - sample valid (always accepted, no backpressure)
//            clr      - clear bins, total and err; restart the window
//            rd_en    - read request
//            rd_idx   - bin index to read (>= NBINS reads as 0)
//            rd_data  - registered bin value
//            rd_val   - one-cycle pulse qualifying rd_data
//            total    - accepted samples in the current window
//            done     - window complete (HOLD state)
//            err      - sticky out-of-range flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cons_hist
  import cons_hist_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int NBINS  = NBINS_DEF,
  parameter int CW     = CW_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      data,
  input  logic               val,
  input  logic               clr,
  input  logic               rd_en,
  input  logic [2:0]         rd_idx,
  output logic [CW-1:0]      rd_data,
  output logic               rd_val,
  output logic [TOTAL_W-1:0] total,
  output logic               done,
  output logic               err
);

  localparam logic [DW-1:0]      C_NBINS  = DW'(NBINS);
  localparam logic [TOTAL_W-1:0] C_WINDOW = TOTAL_W'(WINDOW);

  state_t             state_q, state_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               err_q, err_d;
  logic [CW-1:0]      rd_data_q, rd_data_d;
  logic               rd_val_q, rd_val_d;

  logic               w_in_range;
  logic               w_accept;
  logic [CW-1:0]      w_bins [NBINS];
  logic [CW-1:0]      w_rd_mux;

  // Full-width compare: a large value must never alias into a legal bin.
  assign w_in_range = (data < C_NBINS);

  // clr wins over a same-cycle sample, so it gates the accept.
  assign w_accept = (state_q == ST_COLLECT) && val && w_in_range && !clr;

  generate
    for (genvar gi = 0; gi < NBINS; gi++) begin : g_bins
      hist_bin #(
        .CW (CW)
      ) u_bin (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .inc_i (w_accept && (data == DW'(gi))),
        .cnt_o (w_bins[gi])
      );
    end
  endgenerate

  // Read mux sees the registered bins, so a same-cycle update or clear
  // returns the value from before that edge.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NBINS; i++) begin
      if (rd_idx == 3'(i)) begin
        w_rd_mux = w_bins[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    err_d     = err_q;
    rd_val_d  = rd_en;
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = w_rd_mux;
    end
    if (clr) begin
      state_d = ST_COLLECT;
      total_d = '0;
      err_d   = 1'b0;
    end else if ((state_q == ST_COLLECT) && val) begin
      if (w_in_range) begin
        total_d = total_q + 1'b1;
        if ((total_q + 1'b1) == C_WINDOW) begin
          state_d = ST_HOLD;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_COLLECT;
      total_q   <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      rd_val_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      rd_val_q  <= rd_val_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_val  = rd_val_q;
  assign total   = total_q;
  assign done    = (state_q == ST_HOLD);
  assign err     = err_q;

endmodule : cons_hist

`default_nettype wire

// File: tb/tb_cons_hist.sv
// ============================================================================
// Module   : tb_cons_hist
// Purpose  : Self-checking bench. Three consumers with different geometry
//            (default, WINDOW=4, CW=2) share one stimulus stream; each is
//            compared every cycle against an array-based histogram model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cons_hist;

  localparam int NB = 6;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        val;
  logic        clr;
  logic        rd_en;
  logic [2:0]  rd_idx;

  logic [7:0]  rdd [NI];
  logic [1:0]  rdd_s;
  logic [7:0]  rdd_a, rdd_w;
  logic        rdv [NI];
  logic [15:0] tot [NI];
  logic        dn  [NI];
  logic        er  [NI];

  assign rdd[0] = rdd_a;
  assign rdd[1] = rdd_w;
  assign rdd[2] = {6'b0, rdd_s};

  always #5 clk = ~clk;

  cons_hist #(.DW(8), .NBINS(6), .CW(8), .WINDOW(100)) dut_a (
    .clk(clk), .rst(rst), .data(data), .val(val), .clr(clr),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rdd_a), .rd_val(rdv[0]),
    .total(tot[0]), .done(dn[0]), .err(er[0]));

  cons_hist #(.DW(8), .NBINS(6), .CW(8), .WINDOW(4)) dut_w (
    .clk(clk), .rst(rst), .data(data), .val(val), .clr(clr),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rdd_w), .rd_val(rdv[1]),
    .total(tot[1]), .done(dn[1]), .err(er[1]));

  cons_hist #(.DW(8), .NBINS(6), .CW(2), .WINDOW(100)) dut_s (
    .clk(clk), .rst(rst), .data(data), .val(val), .clr(clr),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rdd_s), .rd_val(rdv[2]),
    .total(tot[2]), .done(dn[2]), .err(er[2]));

  // Reference model: per instance window size, bin ceiling and state
  int win  [NI] = '{100, 4, 100};
  int bmax [NI] = '{255, 255, 3};
  int mb   [NI][NB];
  int mt   [NI];
  int md   [NI];
  int me   [NI];
  int mrd  [NI];
  int mrv  [NI];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int b = 0; b < NB; b++) mb[k][b] = 0;
      mt[k] = 0; md[k] = 0; me[k] = 0; mrd[k] = 0; mrv[k] = 0;
    end
  endtask

  // Applies the inputs present at the clock edge to every model.
  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        for (int b = 0; b < NB; b++) mb[k][b] = 0;
        mt[k] = 0; md[k] = 0; me[k] = 0; mrd[k] = 0; mrv[k] = 0;
      end else begin
        if (rd_en) begin
          mrv[k] = 1;
          mrd[k] = (int'(rd_idx) < NB) ? mb[k][rd_idx] : 0;
        end else begin
          mrv[k] = 0;
        end
        if (clr) begin
          for (int b = 0; b < NB; b++) mb[k][b] = 0;
          mt[k] = 0; md[k] = 0; me[k] = 0;
        end else if (md[k] == 0 && val) begin
          if (int'(data) < NB) begin
            if (mb[k][data] < bmax[k]) mb[k][data] = mb[k][data] + 1;
            mt[k] = mt[k] + 1;
            if (mt[k] == win[k]) md[k] = 1;
          end else begin
            me[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rd_data[%0d]", k), 32'(rdd[k]), 32'(mrd[k]));
      chk($sformatf("rd_val[%0d]", k), 32'(rdv[k]), 32'(mrv[k]));
      chk($sformatf("total[%0d]", k), 32'(tot[k]), 32'(mt[k]));
      chk($sformatf("done[%0d]", k), 32'(dn[k]), 32'(md[k]));
      chk($sformatf("err[%0d]", k), 32'(er[k]), 32'(me[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 0; val = 0; clr = 0; rd_en = 0; data = 0;
  endtask

  task automatic read_bin(input int idx);
    idle();
    rd_en = 1; rd_idx = 3'(idx);
    step();
    rd_en = 0;
  endtask

  task automatic send(input int d);
    idle();
    val = 1; data = 8'(d);
    step();
    val = 0;
  endtask

  task automatic do_clr();
    idle();
    clr = 1;
    step();
    clr = 0;
  endtask

  int exp2 [NB] = '{1, 2, 0, 0, 0, 3};
  int seq2 [6]  = '{0, 1, 1, 5, 5, 5};

  initial begin
    model_reset();
    rd_idx = 0;

    // Reset with a valid sample present: sample must be discarded
    idle();
    rst = 1; val = 1; data = 3;
    step();
    step();
    chk("rst_total", 32'(tot[0]), 32'd0);
    chk("rst_err", 32'(er[0]), 32'd0);
    read_bin(3);
    chk("rst_bin3", 32'(rdd[0]), 32'd0);
    chk("rst_bin3_val", 32'(rdv[0]), 32'd1);
    step();
    chk("rd_val_drop", 32'(rdv[0]), 32'd0);

    // Directed stream
    foreach (seq2[i]) send(seq2[i]);
    for (int b = 0; b < NB; b++) begin
      read_bin(b);
      chk($sformatf("t2_bin%0d", b), 32'(rdd[0]), 32'(exp2[b]));
    end
    chk("t2_total", 32'(tot[0]), 32'd6);
    chk("t2_done", 32'(dn[0]), 32'd0);
    chk("t2_err", 32'(er[0]), 32'd0);
    read_bin(7);
    chk("t2_idx7", 32'(rdd[0]), 32'd0);

    // Out-of-range samples
    do_clr();
    send(6);
    chk("t3_err_first", 32'(er[0]), 32'd1);
    chk("t3_total", 32'(tot[0]), 32'd0);
    send(8'hFF);
    idle();
    step();
    step();
    chk("t3_err_sticky", 32'(er[0]), 32'd1);
    do_clr();
    chk("t3_err_clr", 32'(er[0]), 32'd0);

    // Window boundary on the WINDOW=4 instance
    for (int i = 0; i < 4; i++) send(2);
    chk("t4_done", 32'(dn[1]), 32'd1);
    chk("t4_total4", 32'(tot[1]), 32'd4);
    send(2);
    chk("t4_total5", 32'(tot[1]), 32'd4);
    read_bin(2);
    chk("t4_bin2", 32'(rdd[1]), 32'd4);

    // Clear wins over a simultaneous sample while in HOLD
    idle();
    clr = 1; val = 1; data = 0;
    step();
    chk("t5_done", 32'(dn[1]), 32'd0);
    chk("t5_total", 32'(tot[1]), 32'd0);
    read_bin(0);
    chk("t5_bin0", 32'(rdd[1]), 32'd0);
    send(1);
    chk("t5_collect", 32'(tot[1]), 32'd1);

    // Saturation with a read colliding with the last accept (CW=2)
    do_clr();
    for (int i = 0; i < 4; i++) send(4);
    idle();
    val = 1; data = 4; rd_en = 1; rd_idx = 4;
    step();
    chk("t6_collide", 32'(rdd[2]), 32'd3);
    chk("t6_total", 32'(tot[2]), 32'd5);
    read_bin(4);
    chk("t6_sat", 32'(rdd[2]), 32'd3);

    // Read and clr in the same cycle returns the pre-clear value
    idle();
    clr = 1; rd_en = 1; rd_idx = 4;
    step();
    chk("rd_clr_pre", 32'(rdd[0]), 32'd5);

    // Randomised traffic including mid-window resets and clears
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 79) == 0);
      clr    = ($urandom_range(0, 39) == 0);
      val    = ($urandom_range(0, 3) != 0);
      data   = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      rd_en  = $urandom_range(0, 1) == 1;
      rd_idx = 3'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_cons_hist

`default_nettype wire
